input_conditioner: RTL

- Upstream stage between raw DE0 board inputs (slide switches, push buttons) and the CPU input port / halt line.
- Each input bit is brought into the CPU clock domain with a two-flop synchronizer, then debounced by a per-bit stability counter.
- Outputs per bit: a clean level, a one-cycle rising-edge pulse, and a one-cycle falling-edge pulse.
- The top level consumes levels for input_in and a rising pulse for halt/reset-style requests.

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/input_conditioner_if.sv | 21 ++
 rtl/input_conditioner_debounce_channel.sv | 40 ++++
 rtl/input_conditioner.sv | 46 ++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the board-input conditioner.
// DE0 build defaults plus a short debounce count for simulation benches.
package input_conditioner_pkg;

  localparam int BITS_DE0            = 10;
  localparam int DEBOUNCE_CYCLES_DE0 = 250000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_out_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
// The slave side is the conditioner itself; the master side is its environment.
interface input_conditioner_if #(parameter int BITS = 10);

  logic [BITS-1:0] raw_in;
  logic [BITS-1:0] level_out;
  logic [BITS-1:0] rise_out;
  logic [BITS-1:0] fall_out;
  logic            changed_out;

  modport master (
    output raw_in,
    input  level_out, rise_out, fall_out, changed_out
  );

  modport slave (
    input  raw_in,
    output level_out, rise_out, fall_out, changed_out
  );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One debounced channel: accepts a synchronized value only after it has
// differed from the stable level for DEBOUNCE_CYCLES consecutive edges.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DE0
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      sync_in,
  output chan_out_t chan
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] count;

  // Any return to the stable value discards the partial count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
      chan  <= '0;
    end else if (sync_in == chan.level) begin
      count     <= '0;
      chan.rise <= 1'b0;
      chan.fall <= 1'b0;
    end else if (count == LAST) begin
      count      <= '0;
      chan.level <= sync_in;
      chan.rise  <= sync_in;
      chan.fall  <= ~sync_in;
    end else begin
      count     <= count + CW'(1);
      chan.rise <= 1'b0;
      chan.fall <= 1'b0;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Two-flop synchronizer for asynchronous board inputs followed by one
// independent debounce channel per bit, with level and edge-pulse outputs.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int BITS            = BITS_DE0,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DE0
) (
  input logic                clk,
  input logic                clr,
  input_conditioner_if.slave bus
);

  logic [BITS-1:0] sync1;
  logic [BITS-1:0] sync2;
  chan_out_t       chan [BITS];

  // Plain register pair: nothing may sit between the two synchronizer stages.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < BITS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .clr     (clr),
      .sync_in (sync2[i]),
      .chan    (chan[i])
    );

    assign bus.level_out[i] = chan[i].level;
    assign bus.rise_out[i]  = chan[i].rise;
    assign bus.fall_out[i]  = chan[i].fall;
  end

  assign bus.changed_out = |(bus.rise_out | bus.fall_out);

endmodule
